// File: rtl/proc_param.sv
// proc_param: parametrised multicycle processor. One shared bus, R0-R6 plus R7 as PC, Z/C flags.
// Latency: reg ALU/move N+3, imm ALU/move 2N+5, ld 2N+4 (imm 3N+6), st N+4 cycles (N = WAIT_CYCLES).
// Backpressure: Run low stalls in FETCH only; an instruction in flight always completes.
// Ports: Clock/Reset (async, active-high); Run start/continue; DIN memory read data;
//        DOUT store data, ADDR memory address, W write strobe (all registered); Done last-cycle pulse.
module proc_param #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Run,
    input  logic [DATA_W-1:0] DIN,
    output logic [DATA_W-1:0] DOUT,
    output logic [ADDR_W-1:0] ADDR,
    output logic              W,
    output logic              Done
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0, FWAIT = 4'd1, DECODE = 4'd2, IMMA = 4'd3, IWAIT = 4'd4,
        IMMD   = 4'd5, EXEC  = 4'd6, MWAIT  = 4'd7, LDWB = 4'd8, STW   = 4'd9
    } state_t;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVNZ = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_LD   = 3'b100;
    localparam logic [2:0] OP_ST   = 3'b101;
    localparam logic [2:0] OP_MVNC = 3'b110;
    localparam logic [2:0] OP_AND  = 3'b111;

    // Wait down-counter is loaded with N-1 so each wait state lasts exactly N cycles.
    localparam int               CNT_W    = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   rf [0:6];
    logic [ADDR_W-1:0]   pc;
    logic [9:0]          ir;
    logic [DATA_W-1:0]   imm;
    logic                z, c;
    logic [CNT_W-1:0]    wcnt;

    logic                imm_mode;
    logic [2:0]          op, rx_sel, ry_sel;
    logic [DATA_W-1:0]   rx_val, ry_val, op2, wb_val;
    logic [DATA_W:0]     alu;
    logic                wb_en, flag_en, wait_zero;

    assign imm_mode  = ir[9];
    assign op        = ir[8:6];
    assign rx_sel    = ir[5:3];
    assign ry_sel    = ir[2:0];
    assign wait_zero = (wcnt == '0);
    assign op2       = imm_mode ? imm : ry_val;

    // Register read ports; index 7 returns the already-advanced PC, zero-extended.
    always_comb begin
        rx_val = DATA_W'(pc);
        ry_val = DATA_W'(pc);
        for (int i = 0; i < 7; i++) begin
            if (rx_sel == 3'(i)) rx_val = rf[i];
            if (ry_sel == 3'(i)) ry_val = rf[i];
        end
    end

    // ALU at DATA_W+1 bits: the top bit is carry for add and borrow for sub.
    always_comb begin
        alu = {1'b0, op2};
        case (op)
            OP_ADD:  alu = {1'b0, rx_val} + {1'b0, op2};
            OP_SUB:  alu = {1'b0, rx_val} - {1'b0, op2};
            OP_AND:  alu = {1'b0, rx_val & op2};
            default: alu = {1'b0, op2};
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= FETCH;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        Done      = 1'b0;
        wb_en     = 1'b0;
        wb_val    = alu[DATA_W-1:0];
        flag_en   = 1'b0;
        case (state)
            FETCH:  if (Run) state_nxt = FWAIT;
            FWAIT:  if (wait_zero) state_nxt = DECODE;
            // Decision uses DIN directly since IR is only loaded at the end of this cycle.
            DECODE: state_nxt = (DIN[9] && (DIN[8:6] != OP_ST)) ? IMMA : EXEC;
            IMMA:   state_nxt = IWAIT;
            IWAIT:  if (wait_zero) state_nxt = IMMD;
            IMMD:   state_nxt = EXEC;
            EXEC: begin
                if (op == OP_LD) begin
                    state_nxt = MWAIT;
                end else if (op == OP_ST) begin
                    state_nxt = STW;
                end else begin
                    state_nxt = FETCH;
                    Done      = 1'b1;
                    // Failed conditional moves still finish, they just skip the write.
                    wb_en     = (op == OP_MVNZ) ? !z : (op == OP_MVNC) ? !c : 1'b1;
                    flag_en   = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
                end
            end
            MWAIT:  if (wait_zero) state_nxt = LDWB;
            LDWB: begin
                state_nxt = FETCH;
                Done      = 1'b1;
                wb_en     = 1'b1;
                wb_val    = DIN;
            end
            STW: begin
                state_nxt = FETCH;
                Done      = 1'b1;
            end
            default: state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 7; i++) rf[i] <= '0;
            pc   <= '0;
            ir   <= '0;
            imm  <= '0;
            z    <= 1'b0;
            c    <= 1'b0;
            wcnt <= '0;
            ADDR <= '0;
            DOUT <= '0;
            W    <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (Run) begin
                        ADDR <= pc;
                        pc   <= pc + 1'b1;
                        wcnt <= CNT_LOAD;
                    end
                end
                FWAIT, IWAIT, MWAIT: if (!wait_zero) wcnt <= wcnt - 1'b1;
                DECODE: ir <= DIN[9:0];
                IMMA: begin
                    ADDR <= pc;
                    pc   <= pc + 1'b1;
                    wcnt <= CNT_LOAD;
                end
                IMMD: imm <= DIN;
                EXEC: begin
                    if (op == OP_LD) begin
                        ADDR <= ADDR_W'(op2);
                        wcnt <= CNT_LOAD;
                    end else if (op == OP_ST) begin
                        ADDR <= ADDR_W'(ry_val);
                        DOUT <= rx_val;
                        W    <= 1'b1;
                    end
                    if (flag_en) begin
                        z <= (alu[DATA_W-1:0] == '0);
                        c <= alu[DATA_W];
                    end
                end
                STW: W <= 1'b0;
                default: ;
            endcase
            // Write-back never coincides with the PC increments above (FETCH/IMMA).
            if (wb_en) begin
                if (rx_sel == 3'd7) pc <= wb_val[ADDR_W-1:0];
                for (int i = 0; i < 7; i++) begin
                    if (rx_sel == 3'(i)) rf[i] <= wb_val;
                end
            end
        end
    end
endmodule

// File: tb/tb_proc_param.sv
// tb_proc_param: directed bench for proc_param with three instances:
//   dut_a defaults, dut_b WAIT_CYCLES=3, dut_c ADDR_W=8. Each has a small memory with N-cycle read latency.
// Ports: none.
module tb_proc_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
    logic run_a = 1'b0, run_b = 1'b0, run_c = 1'b0;
    logic [15:0] din_a, dout_a, addr_a;
    logic [15:0] din_b, dout_b, addr_b;
    logic [15:0] din_c, dout_c;
    logic [7:0]  addr_c;
    logic        w_a, w_b, w_c, done_a, done_b, done_c;

    logic [15:0] mem_a [0:255];
    logic [15:0] mem_b [0:255];
    logic [15:0] mem_c [0:255];
    logic [15:0] pipe_b [0:2];

    logic        ld_en = 1'b0;
    logic [1:0]  ld_sel = 2'd0;
    logic [7:0]  ld_addr = 8'd0;
    logic [15:0] ld_dat = 16'd0;

    int checks = 0;
    int errors = 0;

    proc_param dut_a (.Clock(clk), .Reset(rst_a), .Run(run_a), .DIN(din_a),
                      .DOUT(dout_a), .ADDR(addr_a), .W(w_a), .Done(done_a));
    proc_param #(.WAIT_CYCLES(3)) dut_b (.Clock(clk), .Reset(rst_b), .Run(run_b), .DIN(din_b),
                      .DOUT(dout_b), .ADDR(addr_b), .W(w_b), .Done(done_b));
    proc_param #(.ADDR_W(8)) dut_c (.Clock(clk), .Reset(rst_c), .Run(run_c), .DIN(din_c),
                      .DOUT(dout_c), .ADDR(addr_c), .W(w_c), .Done(done_c));

    // Memories: preload port, write on W, read data valid N cycles after ADDR.
    always @(posedge clk) begin
        if (ld_en && ld_sel == 2'd0) mem_a[ld_addr] <= ld_dat;
        else if (w_a) mem_a[addr_a[7:0]] <= dout_a;
        din_a <= mem_a[addr_a[7:0]];
    end
    always @(posedge clk) begin
        if (ld_en && ld_sel == 2'd1) mem_b[ld_addr] <= ld_dat;
        else if (w_b) mem_b[addr_b[7:0]] <= dout_b;
        pipe_b[0] <= mem_b[addr_b[7:0]];
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign din_b = pipe_b[2];
    always @(posedge clk) begin
        if (ld_en && ld_sel == 2'd2) mem_c[ld_addr] <= ld_dat;
        else if (w_c) mem_c[addr_c] <= dout_c;
        din_c <= mem_c[addr_c];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [1:0] sel, input logic [7:0] a, input logic [15:0] d);
        ld_en = 1'b1; ld_sel = sel; ld_addr = a; ld_dat = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    function automatic logic get_done(input int sel);
        case (sel)
            0:       return done_a;
            1:       return done_b;
            default: return done_c;
        endcase
    endfunction

    // Counts cycles from the current one (cycle 1) up to and including the Done cycle.
    task automatic wait_done(input int sel, output int cyc);
        cyc = 1;
        while (!get_done(sel) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("done_seen", 32'(get_done(sel)), 32'd1);
    endtask

    logic [15:0] img_a [0:24];
    logic [15:0] img_b [0:5];

    initial begin
        int cyc;
        int wp;
        int wc;
        img_a = '{16'h0200, 16'h0005, 16'h0210, 16'h1234, 16'h0218, 16'h0077,
                  16'h0200, 16'hFFFF, 16'h0208, 16'h0001, 16'h0081, 16'h0053,
                  16'h0200, 16'h0003, 16'h0208, 16'h0005, 16'h0220, 16'h4444,
                  16'h0228, 16'h5555, 16'h00C1, 16'h01A5, 16'h03C0, 16'h00F0,
                  16'h0132};
        img_b = '{16'h0208, 16'hA5A5, 16'h0210, 16'h0040, 16'h014A, 16'h011A};

        @(negedge clk);
        for (int i = 0; i < 25; i++) poke(2'd0, 8'(i), img_a[i]);
        for (int i = 0; i < 6; i++)  poke(2'd1, 8'(i), img_b[i]);
        poke(2'd2, 8'h00, 16'h0228);
        poke(2'd2, 8'h01, 16'h0123);
        poke(2'd2, 8'h02, 16'h003D);
        poke(2'd2, 8'h23, 16'h0238);
        poke(2'd2, 8'h24, 16'h00FF);
        poke(2'd2, 8'hFF, 16'h0037);

        // Reset state
        check("rst_addr",  32'(addr_a), 32'h0);
        check("rst_dout",  32'(dout_a), 32'h0);
        check("rst_w",     32'(w_a), 32'h0);
        check("rst_done",  32'(done_a), 32'h0);
        check("rst_state", 32'(dut_a.state), 32'd0);
        check("rst_pc",    32'(dut_a.pc), 32'h0);

        // Run low stalls in FETCH
        rst_a = 1'b0;
        repeat (3) @(negedge clk);
        check("stall_state", 32'(dut_a.state), 32'd0);
        check("stall_pc",    32'(dut_a.pc), 32'h0);

        // mv R0,#5
        run_a = 1'b1;
        wait_done(0, cyc);
        check("a_lat_imm_mv", 32'(cyc), 32'd7);
        @(negedge clk);
        check("a_imm_r0", 32'(dut_a.rf[0]), 32'h0005);
        check("a_imm_pc", 32'(dut_a.pc), 32'h0002);
        check("a_imm_z",  32'(dut_a.z), 32'h0);
        check("a_imm_c",  32'(dut_a.c), 32'h0);
        for (int i = 0; i < 4; i++) begin wait_done(0, cyc); @(negedge clk); end

        // add R0,R1 with R0=FFFF, R1=1
        wait_done(0, cyc);
        check("a_lat_add", 32'(cyc), 32'd4);
        @(negedge clk);
        check("add_r0", 32'(dut_a.rf[0]), 32'h0000);
        check("add_z",  32'(dut_a.z), 32'h1);
        check("add_c",  32'(dut_a.c), 32'h1);

        // mvnz R2,R3 with Z=1: no write, Done still pulses
        wait_done(0, cyc);
        check("mvnz_lat", 32'(cyc), 32'd4);
        @(negedge clk);
        check("mvnz_r2", 32'(dut_a.rf[2]), 32'h1234);

        // mv R0,#3 leaves flags alone
        wait_done(0, cyc); @(negedge clk);
        check("mv_r0", 32'(dut_a.rf[0]), 32'h0003);
        check("mv_z_held", 32'(dut_a.z), 32'h1);
        check("mv_c_held", 32'(dut_a.c), 32'h1);
        for (int i = 0; i < 3; i++) begin wait_done(0, cyc); @(negedge clk); end

        // sub R0,R1 : 3-5
        wait_done(0, cyc); @(negedge clk);
        check("sub_r0", 32'(dut_a.rf[0]), 32'hFFFE);
        check("sub_z",  32'(dut_a.z), 32'h0);
        check("sub_c",  32'(dut_a.c), 32'h1);

        // mvnc R4,R5 with C=1
        wait_done(0, cyc); @(negedge clk);
        check("mvnc_r4", 32'(dut_a.rf[4]), 32'h4444);

        // and R0,#00F0
        wait_done(0, cyc);
        check("and_lat", 32'(cyc), 32'd7);
        @(negedge clk);
        check("and_r0", 32'(dut_a.rf[0]), 32'h00F0);
        check("and_z",  32'(dut_a.z), 32'h0);
        check("and_c",  32'(dut_a.c), 32'h0);

        // ld R6,[R2], reset during MWAIT
        for (int i = 0; i < 20 && dut_a.state != 4'd7; i++) @(negedge clk);
        check("ld_mwait_state", 32'(dut_a.state), 32'd7);
        check("ld_addr", 32'(addr_a), 32'h1234);
        rst_a = 1'b1;
        #1;
        check("midrst_addr",  32'(addr_a), 32'h0);
        check("midrst_dout",  32'(dout_a), 32'h0);
        check("midrst_w",     32'(w_a), 32'h0);
        check("midrst_done",  32'(done_a), 32'h0);
        check("midrst_state", 32'(dut_a.state), 32'd0);
        check("midrst_r2",    32'(dut_a.rf[2]), 32'h0);
        @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);
        check("rel_addr",  32'(addr_a), 32'h0);
        check("rel_state", 32'(dut_a.state), 32'd1);
        check("rel_pc",    32'(dut_a.pc), 32'h1);
        rst_a = 1'b1;
        run_a = 1'b0;

        // WAIT_CYCLES=3: st then ld
        rst_b = 1'b0;
        run_b = 1'b1;
        wait_done(1, cyc);
        check("b_lat_imm_mv", 32'(cyc), 32'd11);
        @(negedge clk);
        wait_done(1, cyc); @(negedge clk);
        cyc = 1; wp = 0; wc = 0;
        while (!done_b && cyc < 200) begin
            if (w_b) begin wp++; wc = cyc; end
            @(negedge clk);
            cyc++;
        end
        if (w_b) begin wp++; wc = cyc; end
        check("st_lat",    32'(cyc), 32'd7);
        check("st_pulses", 32'(wp), 32'd1);
        check("st_wcycle", 32'(wc), 32'd7);
        check("st_addr",   32'(addr_b), 32'h0040);
        check("st_dout",   32'(dout_b), 32'hA5A5);
        @(negedge clk);
        check("st_w_low", 32'(w_b), 32'h0);
        check("st_mem",   32'(mem_b[8'h40]), 32'hA5A5);
        wait_done(1, cyc);
        check("ld_lat", 32'(cyc), 32'd10);
        @(negedge clk);
        check("ld_r3", 32'(dut_b.rf[3]), 32'hA5A5);
        rst_b = 1'b1;
        run_b = 1'b0;

        // ADDR_W=8: jump via R7 and PC wrap
        rst_c = 1'b0;
        run_c = 1'b1;
        wait_done(2, cyc); @(negedge clk);
        wait_done(2, cyc);
        check("jmp_lat", 32'(cyc), 32'd4);
        @(negedge clk);
        check("jmp_pc", 32'(dut_c.pc), 32'h23);
        @(negedge clk);
        check("jmp_addr", 32'(addr_c), 32'h23);
        wait_done(2, cyc); @(negedge clk);
        check("jmp2_pc", 32'(dut_c.pc), 32'hFF);
        @(negedge clk);
        check("jmp2_addr", 32'(addr_c), 32'hFF);
        wait_done(2, cyc); @(negedge clk);
        check("wrap_r6", 32'(dut_c.rf[6]), 32'h0);
        check("wrap_pc", 32'(dut_c.pc), 32'h0);
        @(negedge clk);
        check("wrap_addr", 32'(addr_c), 32'h00);
        rst_c = 1'b1;
        run_c = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/proc_param.md
# proc_param

Parametrised successor to the 16-bit multicycle bus processor. It keeps the single shared bus, the eight-register file with R7 as program counter, and the Run/Done handshake. New in this generation:
- configurable data and address widths;
- configurable synchronous-memory wait states;
- an immediate-operand mode for all register-operand instructions, plus an `and` instruction;
- properly registered Z/C flags;
- asynchronous reset of all architectural state.

It sits between the instruction/data memory and the board I/O, as the 16-bit processor did.

## Interface
- DATA_W, 16: register, bus and data-port width; legal range ≥ 10.
- ADDR_W, 16: PC and ADDR width; legal range ≤ DATA_W.
- WAIT_CYCLES, 1: cycles between ADDR capture and valid DIN; legal range ≥ 1.

Ports:
- Clock  in  1  sole clock, rising edge.
- Reset  in  1  asynchronous, active-high.
- Run  in  1  start/continue execution; sampled only in FETCH.
- DIN  in  DATA_W  memory read data.
- DOUT  out  DATA_W  store data (registered).
- ADDR  out  ADDR_W  memory address (registered).
- W  out  1  write strobe (registered).
- Done  out  1  high during the last cycle of each instruction.

## Operation
- Instruction word is DIN[9:0]: [9] Imm, [8:6] III, [5:3] X, [2:0] Y. DIN[DATA_W-1:10] is ignored.
- Op2 = Ry when Imm=0. When Imm=1, Op2 = D, the word following the instruction; PC advances past D.
- Opcodes:
  - 000 mv: Rx←Op2.
  - 001 mvnz: Rx←Op2 if Z=0.
  - 010 add: Rx←Rx+Op2.
  - 011 sub: Rx←Rx−Op2.
  - 100 ld: Rx←mem[Ry], or mem[D] when Imm=1.
  - 101 st: mem[Ry]←Rx. Imm is ignored.
  - 110 mvnc: Rx←Op2 if C=0.
  - 111 and: Rx←Rx&Op2.
- Arithmetic is modulo 2^DATA_W. It is computed at DATA_W+1 bits.
- Flags update only on add, sub and and. Z=(result==0).
  - C for add = carry-out.
  - C for sub = borrow (Rx<Op2 unsigned).
  - C for and = 0.
  - mv, mvnz, mvnc, ld and st leave the flags unchanged.
- R7 = PC.
  - A read of R7 returns the PC zero-extended, already incremented past the instruction and any immediate.
  - A write to R7 takes bus[ADDR_W-1:0], giving a jump or conditional jump.
  - PC wraps from 2^ADDR_W−1 to 0.
- A failed mvnz/mvnc writes nothing and still asserts Done.
- Rx==Ry is legal. The source value is read before the write.
- Run low in FETCH stalls there. Deasserting Run mid-instruction does not abort the instruction.

## Timing
- Reset values: state=FETCH; R0–R7=0; IR=0; Z=C=0; ADDR=0; DOUT=0; W=0; Done=0; wait counter=0. Reset mid-instruction aborts it immediately; no memory write is issued.
- The state machine (N = WAIT_CYCLES):
  - FETCH: if Run, ADDR←PC and PC←PC+1 → FWAIT; otherwise stay.
  - FWAIT: N cycles, counted by a down-counter → DECODE.
  - DECODE: IR←DIN. If Imm=1 and opcode≠st → IMMA; else → EXEC.
  - IMMA: ADDR←PC, PC←PC+1 → IWAIT.
  - IWAIT: N cycles → IMMD.
  - IMMD: operand register←DIN → EXEC.
  - EXEC:
    - mv, mvnz, mvnc, add, sub, and: write Rx and flags, assert Done → FETCH.
    - ld: ADDR←address → MWAIT.
    - st: ADDR←Ry, DOUT←Rx, W register←1 → STW.
  - MWAIT: N cycles → LDWB.
  - LDWB: Rx←DIN, assert Done → FETCH.
  - STW: W=1 for exactly this cycle, with ADDR and DOUT stable. Assert Done; W←0 → FETCH.
- Instruction latency in cycles, from FETCH with Run high to and including the Done cycle:
  - register ALU or move: N+3.
  - immediate ALU or move: 2N+5.
  - ld: 2N+4; with Imm=1: 3N+6.
  - st: N+4.
- Done is a one-cycle pulse. The next FETCH immediately follows the Done cycle.

## Test plan
- Reset mid-instruction: assert Reset during MWAIT of an ld → all outputs 0 and state FETCH immediately. After release with Run=1, the first ADDR is 0.
- Immediate move, defaults: mem[0]=0x0200, mem[1]=0x0005 → R0=0x0005 and Done in cycle 7. PC=2, Z/C unchanged.
- add/mvnz: R0=0xFFFF, R1=0x0001, add R0,R1 → R0=0, Z=1, C=1. Then mvnz R2,R3 → R2 unchanged and Done still pulses.
- sub/mvnc: R0=3, R1=5, sub R0,R1 → R0=0xFFFE, Z=0, C=1. Then mvnc R4,R5 → R4 unchanged. Then and R0,#0x00F0 → R0=0x00F0, C=0.
- WAIT_CYCLES=3: st R1,[R2] with R1=0xA5A5, R2=0x0040 → single W pulse in cycle 7 with ADDR=0x40 and DOUT=0xA5A5. Then ld R3,[R2] → R3=0xA5A5 and Done in cycle 10.
- Jump and wrap, ADDR_W=8: mv R7,R5 with R5=0x0123 → next fetch ADDR=0x23. Executing at 0xFF → next fetch ADDR=0x00.
